// File: rtl/contador_3bits_updown_pkg.sv
// Shared types and constants for the 3-bit up/down counter.
package contador_3bits_updown_pkg;

  localparam int CNT_W = 3;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef logic [CNT_W-1:0] count_t;

  // One-hot decode of a count value, used for the display scan select.
  function automatic logic [7:0] onehot(input count_t c);
    return 8'(1) << c;
  endfunction

endpackage

// File: rtl/contador_3bits_updown_tff.sv
// T flip-flop with synchronous active-high reset to a per-instance value.
module t_flip_flop_sync (
  input  logic clk_div,
  input  logic reset,
  input  logic rst_val,
  input  logic t,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_div) begin
    if (reset) begin
      q <= rst_val;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/contador_3bits_updown.sv
// Synchronous 3-bit up/down counter with parallel load and programmable modulus.
// Optional one-hot scan output sel is enabled by defining CONTADOR_ONEHOT_EN.
module contador_3bits_updown
  import contador_3bits_updown_pkg::*;
#(
  parameter int MODULO    = 8,
  parameter int RESET_VAL = 7
) (
  input  logic       clk_div,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] d,
  output logic       q0,
  output logic       q1,
  output logic       q2,
  output logic       tc
`ifdef CONTADOR_ONEHOT_EN
  ,
  output logic [7:0] sel
`endif
);

  localparam count_t MAX_CNT = count_t'(MODULO - 1);
  localparam count_t RST_CNT = count_t'(RESET_VAL);

  count_t count;
  count_t toggle;
  count_t next_count;
  count_t load_val;
  count_t wrap_val;
  logic   wrap;

  assign count = {q2, q1, q0};

  // NOTE: every always_comb output gets a default first so no path
  // through the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    toggle   = '0;
    load_val = (d > MAX_CNT) ? MAX_CNT : d;
    wrap_val = (dir == DIR_UP) ? count_t'(0) : MAX_CNT;
    wrap     = en && ((dir == DIR_UP) ? (count == MAX_CNT) : (count == '0));

    // Load and wrap jump to an arbitrary value, so toggle exactly the bits
    // that differ; a plain step uses the classic carry/borrow chain.
    if (load) begin
      toggle = count ^ load_val;
    end else if (wrap) begin
      toggle = count ^ wrap_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        toggle = {q1 & q0, q0, 1'b1};
      end else begin
        toggle = {~q1 & ~q0, ~q0, 1'b1};
      end
    end

    next_count = count ^ toggle;
  end

  t_flip_flop_sync u_tff0 (
    .clk_div (clk_div),
    .reset   (reset),
    .rst_val (RST_CNT[0]),
    .t       (toggle[0]),
    .q       (q0)
  );

  t_flip_flop_sync u_tff1 (
    .clk_div (clk_div),
    .reset   (reset),
    .rst_val (RST_CNT[1]),
    .t       (toggle[1]),
    .q       (q1)
  );

  t_flip_flop_sync u_tff2 (
    .clk_div (clk_div),
    .reset   (reset),
    .rst_val (RST_CNT[2]),
    .t       (toggle[2]),
    .q       (q2)
  );

  // tc marks only the cycle in which q shows a wrapped value.
  always_ff @(posedge clk_div) begin
    if (reset) begin
      tc <= 1'b0;
    end else begin
      tc <= wrap && !load;
    end
  end

`ifdef CONTADOR_ONEHOT_EN
  always_ff @(posedge clk_div) begin
    if (reset) begin
      sel <= onehot(RST_CNT);
    end else begin
      sel <= onehot(next_count);
    end
  end
`endif

endmodule

// File: tb/tb_contador_3bits_updown.sv
// Scoreboard bench for contador_3bits_updown: MODULO=8/RESET_VAL=7 and MODULO=6/RESET_VAL=5.
module tb_contador_3bits_updown;

  typedef struct packed {
    logic [2:0] q;
    logic       tc;
    logic [7:0] sel;
  } exp_t;

  logic       clk_div = 1'b0;
  logic       reset   = 1'b0;
  logic       en      = 1'b0;
  logic       dir     = 1'b0;
  logic       load    = 1'b0;
  logic [2:0] d       = '0;

  logic q0_8, q1_8, q2_8, tc_8;
  logic q0_6, q1_6, q2_6, tc_6;
  logic [7:0] sel_8, sel_6;

  int errors = 0;
  int checks = 0;

  exp_t sb8[$];
  exp_t sb6[$];
  int   m8 = 0;
  int   m6 = 0;

  always #5 clk_div = ~clk_div;

  contador_3bits_updown #(.MODULO(8), .RESET_VAL(7)) dut8 (
    .clk_div (clk_div),
    .reset   (reset),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .d       (d),
    .q0      (q0_8),
    .q1      (q1_8),
    .q2      (q2_8),
    .tc      (tc_8)
`ifdef CONTADOR_ONEHOT_EN
    ,
    .sel     (sel_8)
`endif
  );

  contador_3bits_updown #(.MODULO(6), .RESET_VAL(5)) dut6 (
    .clk_div (clk_div),
    .reset   (reset),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .d       (d),
    .q0      (q0_6),
    .q1      (q1_6),
    .q2      (q2_6),
    .tc      (tc_6)
`ifdef CONTADOR_ONEHOT_EN
    ,
    .sel     (sel_6)
`endif
  );

`ifndef CONTADOR_ONEHOT_EN
  assign sel_8 = '0;
  assign sel_6 = '0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference behaviour written straight from the counter's definition.
  function automatic exp_t model(input int cur, input int modulo, input int rstval,
                                 input logic r, input logic e, input logic dr,
                                 input logic l, input logic [2:0] dv);
    exp_t x;
    int   n;
    x.tc = 1'b0;
    if (r)                  n = rstval;
    else if (l)             n = (int'(dv) >= modulo) ? modulo - 1 : int'(dv);
    else if (e && dr) begin
      if (cur == modulo - 1) begin n = 0; x.tc = 1'b1; end
      else n = cur + 1;
    end else if (e) begin
      if (cur == 0) begin n = modulo - 1; x.tc = 1'b1; end
      else n = cur - 1;
    end else                n = cur;
    x.q   = 3'(n);
    x.sel = 8'(1) << n;
    return x;
  endfunction

  task automatic compare(input string name, input exp_t e,
                         input logic [2:0] q, input logic tc, input logic [7:0] sel);
    check({name, ".q"},  32'(q),  32'(e.q));
    check({name, ".tc"}, 32'(tc), 32'(e.tc));
`ifdef CONTADOR_ONEHOT_EN
    check({name, ".sel"}, 32'(sel), 32'(e.sel));
`else
    if (sel !== 8'h00) check({name, ".sel_absent"}, 32'(sel), 32'h0);
`endif
  endtask

  task automatic step(input logic r, input logic e, input logic dr,
                      input logic l, input logic [2:0] dv, input string name);
    exp_t x8, x6;
    reset = r; en = e; dir = dr; load = l; d = dv;
    x8 = model(m8, 8, 7, r, e, dr, l, dv);
    x6 = model(m6, 6, 5, r, e, dr, l, dv);
    m8 = int'(x8.q);
    m6 = int'(x6.q);
    sb8.push_back(x8);
    sb6.push_back(x6);
    @(posedge clk_div);
    #1;
    compare({name, "/m8"}, sb8.pop_front(), {q2_8, q1_8, q0_8}, tc_8, sel_8);
    compare({name, "/m6"}, sb6.pop_front(), {q2_6, q1_6, q0_6}, tc_6, sel_6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk_div);

    // Reset state: 7 / 5, tc low.
    step(1, 0, 0, 0, 3'd0, "reset");
    // Count down through a full lap; m8 wraps 0->7, m6 wraps 0->5.
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 3'd0, $sformatf("down%0d", i));
    // Hold after wrap: tc must clear.
    step(0, 0, 0, 0, 3'd0, "hold_after_wrap");

    // Up from reset value: m6 gives 5,0,1,2 with tc on the 0.
    step(1, 0, 0, 0, 3'd0, "reset_up");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 3'd0, $sformatf("up%0d", i));

    // Load wins over counting; d=7 clamps to 5 on the modulo-6 instance.
    step(0, 1, 1, 1, 3'd3, "load3");
    step(0, 1, 1, 1, 3'd7, "load7");
    step(0, 0, 0, 1, 3'd6, "load6_en0");

    // Load 7 then down to 2, then reset with load asserted.
    step(0, 0, 0, 1, 3'd7, "load7b");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 3'd0, $sformatf("to2_%0d", i));
    step(1, 1, 0, 1, 3'd4, "reset_over_load");

    // Down to 4, hold three cycles, then up one and down one.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3'd0, $sformatf("to4_%0d", i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 3'd0, $sformatf("hold%0d", i));
    step(0, 1, 1, 0, 3'd0, "resume_up");
    step(0, 1, 0, 0, 3'd0, "resume_down");

    // Randomised mix of all controls.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 7) == 0), 3'($urandom),
           $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
